// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the instruction cache.
package icache_pkg;

  localparam int AddrWidth        = 32;
  localparam int InstrWidth       = 32;
  localparam int ICacheIndexWidth = 8;

  // Allocator length field is bytes-1; a whole instruction word is 4 bytes.
  localparam logic [1:0] WordOffset = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits with async clear, tag and data
// arrays without reset. Combinational read port, synchronous write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int TAG_WIDTH   = AddrWidth - ICacheIndexWidth - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [InstrWidth-1:0]  rd_data_o,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [InstrWidth-1:0]  wr_data_i
);

  localparam int Lines = 1 << INDEX_WIDTH;

  logic [Lines-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [Lines];
  logic [InstrWidth-1:0] data_q [Lines];

  // Valid bits: cleared asynchronously, set by a fill.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload: written on fill, contents undefined until then.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-instruction-per-line instruction cache. Hits answer
// one cycle after the request; misses fetch one word from the allocator,
// fill the line and forward the word. A branch clear aborts any miss.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int ADDR_WIDTH  = AddrWidth
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear_branch_in,
  input  logic                  fetch_en_in,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_in,
  output logic                  fetch_done_out,
  output logic [InstrWidth-1:0] fetch_instr_out,
  output logic                  alloc_en_out,
  output logic [ADDR_WIDTH-1:0] alloc_a_out,
  output logic [1:0]            alloc_offset_out,
  input  logic                  alloc_gr_in,
  input  logic                  alloc_data_en_in,
  input  logic [InstrWidth-1:0] alloc_d_in
);

  localparam int TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

  state_e                state_q;
  logic                  done_q;
  logic [InstrWidth-1:0] instr_q;
  logic                  alloc_en_q;
  logic [ADDR_WIDTH-1:0] alloc_a_q;
  logic [1:0]            alloc_off_q;

  logic [INDEX_WIDTH-1:0] pc_idx;
  logic [TagWidth-1:0]    pc_tag;
  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TagWidth-1:0]    fill_tag;
  logic                   rd_valid;
  logic [TagWidth-1:0]    rd_tag;
  logic [InstrWidth-1:0]  rd_data;
  logic                   hit;
  logic                   fill_we;
  logic                   unused_pc_bits;

  // Byte-lane bits of the pc never matter: fetches are whole words.
  assign unused_pc_bits = ^fetch_pc_in[1:0];

  assign pc_idx   = fetch_pc_in[INDEX_WIDTH+1:2];
  assign pc_tag   = fetch_pc_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // The latched request address doubles as the fill address.
  assign fill_idx = alloc_a_q[INDEX_WIDTH+1:2];
  assign fill_tag = alloc_a_q[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign hit = rd_valid && (rd_tag == pc_tag);

  // Fill only when the data beat is not cancelled by a clear and the
  // pipeline is not stalled.
  assign fill_we = rdy_in && !clear_branch_in && (state_q == S_WAIT) && alloc_data_en_in;

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TagWidth)
  ) u_array (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (fill_idx),
    .wr_tag_i   (fill_tag),
    .wr_data_i  (alloc_d_in)
  );

  // Fetch FSM with registered outputs; rdy_in low freezes everything,
  // which stretches any pulse in flight instead of losing it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      instr_q     <= '0;
      alloc_en_q  <= 1'b0;
      alloc_a_q   <= '0;
      alloc_off_q <= '0;
    end else if (rdy_in) begin
      done_q <= 1'b0;
      if (clear_branch_in) begin
        // Clear wins over grant, data and any pending done pulse.
        alloc_en_q  <= 1'b0;
        alloc_off_q <= '0;
        state_q     <= ((state_q == S_WAIT) && alloc_data_en_in) ? S_DROP : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Skip evaluation during the done pulse so a held request
            // is not answered twice.
            if (fetch_en_in && !done_q) begin
              if (hit) begin
                done_q  <= 1'b1;
                instr_q <= rd_data;
              end else begin
                alloc_en_q  <= 1'b1;
                alloc_a_q   <= {fetch_pc_in[ADDR_WIDTH-1:2], 2'b00};
                alloc_off_q <= WordOffset;
                state_q     <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (alloc_gr_in) begin
              alloc_en_q  <= 1'b0;
              alloc_off_q <= '0;
              state_q     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (alloc_data_en_in) begin
              instr_q <= alloc_d_in;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          S_DROP: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fetch_done_out   = done_q;
  assign fetch_instr_out  = instr_q;
  assign alloc_en_out     = alloc_en_q;
  assign alloc_a_out      = alloc_a_q;
  assign alloc_offset_out = alloc_off_q;

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: the bench plays both the fetch stage and
// the allocator, and keeps a line-address model of the cache contents.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_branch_in;
  logic        fetch_en_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_done_out;
  logic [31:0] fetch_instr_out;
  logic        alloc_en_out;
  logic [31:0] alloc_a_out;
  logic [1:0]  alloc_offset_out;
  logic        alloc_gr_in;
  logic        alloc_data_en_in;
  logic [31:0] alloc_d_in;

  always #5 clk = ~clk;

  icache #(.INDEX_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n_in),
    .rdy_in           (rdy_in),
    .clear_branch_in  (clear_branch_in),
    .fetch_en_in      (fetch_en_in),
    .fetch_pc_in      (fetch_pc_in),
    .fetch_done_out   (fetch_done_out),
    .fetch_instr_out  (fetch_instr_out),
    .alloc_en_out     (alloc_en_out),
    .alloc_a_out      (alloc_a_out),
    .alloc_offset_out (alloc_offset_out),
    .alloc_gr_in      (alloc_gr_in),
    .alloc_data_en_in (alloc_data_en_in),
    .alloc_d_in       (alloc_d_in)
  );

  int checks = 0;
  int errors = 0;

  // Model: for each cache index, the word address currently resident.
  int unsigned line_addr [int];

  // Expectations shared with the per-cycle compare process.
  bit          done_expected = 0;
  bit          miss_pending  = 0;
  logic [31:0] exp_instr     = '0;
  logic [31:0] exp_addr      = '0;
  logic [31:0] last_alloc_a;
  logic [1:0]  last_off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as seen through the allocator.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h4) return 32'h0010_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int          idx;
    logic [31:0] wa;
    idx = int'(pc[9:2]);
    wa  = {pc[31:2], 2'b00};
    return line_addr.exists(idx) && (line_addr[idx] == wa);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle output checks against the current expectation.
  always @(negedge clk) begin
    if (rst_n_in) begin
      chk("offset_vs_en", {30'd0, alloc_offset_out}, alloc_en_out ? 32'd3 : 32'd0);
      if (alloc_en_out) begin
        chk("alloc_addr", alloc_a_out, exp_addr);
        chk("alloc_unexpected", {31'd0, miss_pending}, 32'd1);
      end
      if (fetch_done_out) begin
        chk("done_unexpected", {31'd0, done_expected}, 32'd1);
        chk("instr", fetch_instr_out, exp_instr);
      end
    end
  end

  // One fetch transaction. mode: 0 normal, 1 clear in WAIT (allocator
  // then suppresses data), 2 clear coincident with data, 3 clear in REQ.
  task automatic do_fetch(input logic [31:0] pc, input int gdly, input int ddly,
                          input int mode, input bit stall, input bit stretch);
    logic [31:0] wa;
    wa           = {pc[31:2], 2'b00};
    last_alloc_a = '0;
    last_off     = '0;
    fetch_pc_in  = pc;
    fetch_en_in  = 1'b1;
    if (model_hit(pc)) begin
      exp_instr     = mem_word(wa);
      done_expected = 1'b1;
      step();
      chk("hit_done", {31'd0, fetch_done_out}, 32'd1);
      chk("hit_no_alloc", {31'd0, alloc_en_out}, 32'd0);
      fetch_en_in = 1'b0;
      if (stretch) begin
        rdy_in = 1'b0;
        repeat (2) begin
          step();
          chk("stretch_done", {31'd0, fetch_done_out}, 32'd1);
        end
        rdy_in = 1'b1;
      end
      step();
      chk("hit_pulse_end", {31'd0, fetch_done_out}, 32'd0);
      done_expected = 1'b0;
    end else begin
      exp_addr      = wa;
      miss_pending  = 1'b1;
      done_expected = 1'b0;
      step();
      chk("miss_alloc_en", {31'd0, alloc_en_out}, 32'd1);
      chk("miss_no_done", {31'd0, fetch_done_out}, 32'd0);
      last_alloc_a = alloc_a_out;
      last_off     = alloc_offset_out;
      if (stall) begin
        rdy_in = 1'b0;
        repeat (3) begin
          step();
          chk("stall_hold_en", {31'd0, alloc_en_out}, 32'd1);
        end
        rdy_in = 1'b1;
      end
      if (mode == 3) begin
        alloc_gr_in     = 1'($urandom_range(0, 1));
        clear_branch_in = 1'b1;
        fetch_en_in     = 1'b0;
        step();
        alloc_gr_in     = 1'b0;
        clear_branch_in = 1'b0;
        miss_pending    = 1'b0;
        chk("req_clear_en", {31'd0, alloc_en_out}, 32'd0);
        step();
        chk("req_clear_nodone", {31'd0, fetch_done_out}, 32'd0);
      end else begin
        repeat (gdly) step();
        alloc_gr_in = 1'b1;
        step();
        alloc_gr_in  = 1'b0;
        miss_pending = 1'b0;
        chk("grant_fall", {31'd0, alloc_en_out}, 32'd0);
        if (mode == 1) begin
          clear_branch_in = 1'b1;
          fetch_en_in     = 1'b0;
          step();
          clear_branch_in = 1'b0;
          repeat (ddly + 1) step();
          chk("flush_nodone", {31'd0, fetch_done_out}, 32'd0);
        end else begin
          repeat (ddly) step();
          alloc_data_en_in = 1'b1;
          alloc_d_in       = mem_word(wa);
          if (mode == 2) begin
            clear_branch_in = 1'b1;
            fetch_en_in     = 1'b0;
            step();
            alloc_data_en_in = 1'b0;
            clear_branch_in  = 1'b0;
            alloc_d_in       = $urandom;
            chk("drop_nodone", {31'd0, fetch_done_out}, 32'd0);
            step();
            chk("drop_nodone2", {31'd0, fetch_done_out}, 32'd0);
          end else begin
            exp_instr     = mem_word(wa);
            done_expected = 1'b1;
            step();
            alloc_data_en_in = 1'b0;
            alloc_d_in       = $urandom;
            chk("fill_done", {31'd0, fetch_done_out}, 32'd1);
            chk("fill_instr", fetch_instr_out, exp_instr);
            fetch_en_in = 1'b0;
            line_addr[int'(wa[9:2])] = wa;
            step();
            chk("fill_pulse_end", {31'd0, fetch_done_out}, 32'd0);
            done_expected = 1'b0;
          end
        end
      end
    end
    fetch_en_in = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int          r;
    int          mode;
    rst_n_in         = 1'b0;
    rdy_in           = 1'b1;
    clear_branch_in  = 1'b0;
    fetch_en_in      = 1'b0;
    fetch_pc_in      = '0;
    alloc_gr_in      = 1'b0;
    alloc_data_en_in = 1'b0;
    alloc_d_in       = '0;

    #12;
    chk("reset_done", {31'd0, fetch_done_out}, 32'd0);
    chk("reset_instr", fetch_instr_out, 32'd0);
    chk("reset_alloc_en", {31'd0, alloc_en_out}, 32'd0);
    chk("reset_alloc_a", alloc_a_out, 32'd0);
    chk("reset_offset", {30'd0, alloc_offset_out}, 32'd0);
    rst_n_in = 1'b1;
    step();

    // Cold miss at 0x4, with a 3-cycle stall while requesting.
    chk("model_cold_miss", {31'd0, model_hit(32'h4)}, 32'd0);
    do_fetch(32'h0000_0004, 1, 2, 0, 1'b1, 1'b0);
    chk("cold_alloc_a", last_alloc_a, 32'h0000_0004);
    chk("cold_offset", {30'd0, last_off}, 32'd3);
    chk("cold_instr", fetch_instr_out, 32'h0010_0093);

    // Hit after fill, with the done pulse stretched by a stall.
    chk("model_hit_after_fill", {31'd0, model_hit(32'h4)}, 32'd1);
    do_fetch(32'h0000_0004, 0, 0, 0, 1'b0, 1'b1);

    // Conflict on index 1, then the original pc misses again.
    chk("model_conflict_miss", {31'd0, model_hit(32'h404)}, 32'd0);
    do_fetch(32'h0000_0404, 0, 1, 0, 1'b0, 1'b0);
    chk("conflict_alloc_a", last_alloc_a, 32'h0000_0404);
    do_fetch(32'h0000_0004, 2, 0, 0, 1'b0, 1'b0);
    chk("refill_alloc_a", last_alloc_a, 32'h0000_0004);

    // Flush in WAIT on an index-1 miss: line 1 must still hold 0x4.
    do_fetch(32'h0000_0804, 0, 2, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 0, 0, 0, 1'b0, 1'b0);
    chk("line1_kept", fetch_instr_out, 32'h0010_0093);

    // Clear coincident with data: no fill, so the pc misses again.
    do_fetch(32'h0000_0808, 1, 1, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0808, 0, 0, 0, 1'b0, 1'b0);
    chk("drop_no_fill", last_alloc_a, 32'h0000_0808);

    // Async reset while waiting for data.
    fetch_pc_in  = 32'h0000_0C08;
    fetch_en_in  = 1'b1;
    exp_addr     = 32'h0000_0C08;
    miss_pending = 1'b1;
    step();
    alloc_gr_in = 1'b1;
    step();
    alloc_gr_in  = 1'b0;
    miss_pending = 1'b0;
    #3 rst_n_in = 1'b0;
    #1;
    chk("arst_done", {31'd0, fetch_done_out}, 32'd0);
    chk("arst_instr", fetch_instr_out, 32'd0);
    chk("arst_alloc_en", {31'd0, alloc_en_out}, 32'd0);
    chk("arst_alloc_a", alloc_a_out, 32'd0);
    chk("arst_offset", {30'd0, alloc_offset_out}, 32'd0);
    fetch_en_in = 1'b0;
    line_addr.delete();
    #2 rst_n_in = 1'b1;
    step();
    do_fetch(32'h0000_0004, 0, 0, 0, 1'b0, 1'b0);
    chk("post_reset_miss", last_alloc_a, 32'h0000_0004);

    // Randomized traffic over a small pc pool to mix hits and conflicts.
    for (int t = 0; t < 250; t++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 31);
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), mode,
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-instruction-per-line instruction cache between the instruction-fetch stage and the memory allocator.
- Hits return an instruction one cycle after the request.
- Misses issue a 4-byte read to the allocator's IF port, fill the line from the returned word and forward that word.
- A branch flush aborts any miss in flight and discards its data.

## Interface
Parameters:
- INDEX_WIDTH, 8: log2 of line count (256 lines).
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- rdy_in  in  1  global stall. When low, all state and outputs hold.
- clear_branch_in  in  1  flush. Aborts the outstanding fetch.
- fetch_en_in  in  1  IF request. Held high until fetch_done_out.
- fetch_pc_in  in  ADDR_WIDTH  fetch address. Bits [1:0] are ignored.
- fetch_done_out  out  1  one-cycle pulse: fetch_instr_out is valid.
- fetch_instr_out  out  32  instruction.
- alloc_en_out  out  1  read request to the allocator.
- alloc_a_out  out  ADDR_WIDTH  word-aligned read address ({pc[31:2],2'b00}).
- alloc_offset_out  out  2  bytes-1. Constant 2'b11 while requesting, else 0.
- alloc_gr_in  in  1  allocator grant pulse.
- alloc_data_en_in  in  1  allocator data-valid pulse.
- alloc_d_in  in  32  returned word, little-endian assembled.

## Operation
Address split:
- index = pc[INDEX_WIDTH+1:2].
- tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].

Each line holds valid(1), tag, data(32). All valid bits clear on reset; tag and data RAM contents are not reset.

FSM states: IDLE, REQ, WAIT, DROP.
- IDLE, fetch_en_in high, hit: next cycle pulse fetch_done_out with the line data. Stay in IDLE, except that the request is not re-evaluated in the done-pulse cycle (avoids a double hit on a held request).
- IDLE, fetch_en_in high, miss: latch pc → REQ. Drive alloc_en_out=1, alloc_a_out=latched word address, alloc_offset_out=3.
- REQ: hold request signals until alloc_gr_in. On the grant cycle, drop alloc_en_out on the next edge → WAIT.
- WAIT, alloc_data_en_in: write line (valid=1, tag, data=alloc_d_in). Drive fetch_instr_out=alloc_d_in and pulse fetch_done_out next cycle → IDLE.

clear_branch_in (sampled when rdy_in high) overrides everything:
- REQ or WAIT → IDLE. Deassert alloc_en_out. No line write, no done pulse.
- A done pulse already scheduled for the next cycle is suppressed.
- DROP is reserved for the case where alloc_data_en_in coincides with a clear: the data is discarded. Allocator flush semantics guarantee no later stale data, so DROP returns to IDLE after one cycle.

Other rules:
- The IF pc may change only after fetch_done_out or clear_branch_in. A pc change mid-miss is not supported.
- No write path: instruction memory is read-only, no coherence with store traffic.

Reset values (asynchronous, rst_n_in low): state=IDLE, fetch_done_out=0, fetch_instr_out=0, alloc_en_out=0, alloc_a_out=0, alloc_offset_out=0, all valid bits=0. Reset mid-miss abandons the request immediately.

## Timing
- Hit latency: request sampled at edge N, fetch_done_out high during cycle N+1. Throughput: one hit per 2 cycles per held request; back-to-back distinct pcs sustain one hit every 2 cycles.
- Miss latency: 1 (detect) + allocator grant wait + allocator data latency + 1 (forward). With an idle allocator, fetch_done_out follows the request by ≥7 cycles.
- alloc_en_out is registered. It rises the cycle after the miss is detected and falls the cycle after alloc_gr_in.
- rdy_in low freezes FSM, outputs and arrays. Pulses are extended, not lost.
- Simultaneous alloc_gr_in and clear_branch_in: clear wins → IDLE.
- A fill overwrites a conflicting line unconditionally.

## Structure
- Constants in the shared config.vh: `AddrWidth, `InstrWidth, `TRUE, `FALSE, `ZERO, and a new `ICacheIndexWidth.
- One sub-module, icache_array: valid/tag/data storage with a combinational read port and a synchronous write port. Valid bits use async clear.
- FSM and handshake logic live in icache.

## Test plan
- Cold miss: pc=0x0000_0004, allocator returns 0x0010_0093 → alloc_a_out=0x4, offset=3; fetch_done_out with instr 0x0010_0093; line 1 valid.
- Hit after fill: same pc re-requested → fetch_done_out next cycle, alloc_en_out stays 0.
- Conflict: pc=0x0000_0404 (same index, different tag) → miss, refill; then pc=0x4 misses again.
- Flush in WAIT: clear_branch_in one cycle after grant, data pulse afterwards suppressed by allocator → no done pulse, line 1 unchanged, state IDLE.
- Clear coincident with alloc_data_en_in → no fill, no done pulse.
- rdy_in low for 3 cycles during REQ → alloc_en_out held high, request not re-issued; async reset mid-WAIT → all outputs 0 before the next edge.
